// File: rtl/i2c_target_fsm_pkg.sv
// Shared types and helpers for the I2C target engine.
// Holds the FSM state encoding and the address-match rule.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK_CHK,
    WAIT_STOP
  } i2c_tgt_state_e;

  // General call is write-only, so a read to 7'h00 never matches through gen_en.
  function automatic logic addr_hit(input logic [7:0]            addr_byte,
                                    input logic [I2C_ADDR_W-1:0] own,
                                    input logic                  gen_en);
    return (addr_byte[7:1] == own) || (gen_en && (addr_byte == 8'h00));
  endfunction

endpackage

// File: rtl/i2c_target_fsm_line_sync.sv
// Synchroniser plus history flop for one open-drain bus line.
// Edges are suppressed until the chain holds real pad samples after reset.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
      r_hist <= 1'b1;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], line_i};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_valid = r_fill[SYNC_STAGES];
  assign line_s  = r_sync[SYNC_STAGES-1];
  assign rise    = w_valid &  line_s & ~r_hist;
  assign fall    = w_valid & ~line_s &  r_hist;

endmodule

// File: rtl/i2c_target_fsm.sv
// I2C target engine: START/STOP detection, address match, byte receive and
// transmit with a pulse-based register-side handshake. Drives SDA only.
module i2c_target_fsm
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit GEN_CALL_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  input  logic [I2C_ADDR_W-1:0] own_addr,
  output logic [7:0]            rx_dat,
  output logic                  rx_dat_valid,
  input  logic [7:0]            tx_dat,
  output logic                  tx_req,
  output logic                  rd_wr,
  output logic                  addressed,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  nack_rcvd,
  output logic                  busy
);

  logic w_scl_s, w_scl_rise, w_scl_fall;
  logic w_sda_s, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .line_i(scl_i),
    .line_s(w_scl_s), .rise(w_scl_rise), .fall(w_scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .line_i(sda_i),
    .line_s(w_sda_s), .rise(w_sda_rise), .fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_s;
  assign w_stop  = w_sda_rise & w_scl_s;

  i2c_tgt_state_e r_state, w_state_next;
  logic [7:0] r_shift, w_shift_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic       r_byte_full, w_byte_full_next;
  logic       r_ack_ok, w_ack_ok_next;
  logic       r_sda_o, w_sda_o_next;
  logic       r_addressed, w_addressed_next;
  logic       r_rd_wr, w_rd_wr_next;
  logic [7:0] r_rx_dat, w_rx_dat_next;
  logic       r_rx_valid, w_rx_valid_next;
  logic       r_tx_req, w_tx_req_next;
  logic       r_start_det, w_start_det_next;
  logic       r_stop_det, w_stop_det_next;
  logic       r_nack, w_nack_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_full <= 1'b0;
      r_ack_ok    <= 1'b0;
      r_sda_o     <= 1'b1;
      r_addressed <= 1'b0;
      r_rd_wr     <= 1'b0;
      r_rx_dat    <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_nack      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_byte_full <= w_byte_full_next;
      r_ack_ok    <= w_ack_ok_next;
      r_sda_o     <= w_sda_o_next;
      r_addressed <= w_addressed_next;
      r_rd_wr     <= w_rd_wr_next;
      r_rx_dat    <= w_rx_dat_next;
      r_rx_valid  <= w_rx_valid_next;
      r_tx_req    <= w_tx_req_next;
      r_start_det <= w_start_det_next;
      r_stop_det  <= w_stop_det_next;
      r_nack      <= w_nack_next;
    end
  end

  // r_byte_full marks that the 8th rise of a byte has been seen, so the
  // following fall is the byte boundary (bit_cnt alone is 0 at both ends).
  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_bit_cnt_next   = r_bit_cnt;
    w_byte_full_next = r_byte_full;
    w_ack_ok_next    = r_ack_ok;
    w_sda_o_next     = r_sda_o;
    w_addressed_next = r_addressed;
    w_rd_wr_next     = r_rd_wr;
    w_rx_dat_next    = r_rx_dat;
    w_rx_valid_next  = 1'b0;
    w_tx_req_next    = 1'b0;
    w_start_det_next = 1'b0;
    w_stop_det_next  = 1'b0;
    w_nack_next      = 1'b0;

    if (w_start) begin
      w_start_det_next = 1'b1;
      w_addressed_next = 1'b0;
      w_sda_o_next     = 1'b1;
      w_bit_cnt_next   = '0;
      w_byte_full_next = 1'b0;
      w_state_next     = ADDR;
    end else if (w_stop) begin
      w_stop_det_next  = 1'b1;
      w_addressed_next = 1'b0;
      w_sda_o_next     = 1'b1;
      w_state_next     = IDLE;
    end else begin
      case (r_state)
        ADDR, RX_DATA: begin
          if (w_scl_rise) begin
            w_shift_next   = {r_shift[6:0], w_sda_s};
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_byte_full_next = 1'b1;
          end else if (w_scl_fall && r_byte_full) begin
            w_byte_full_next = 1'b0;
            if (r_state == RX_DATA) begin
              w_rx_dat_next   = r_shift;
              w_rx_valid_next = 1'b1;
              w_sda_o_next    = 1'b0;
              w_state_next    = RX_ACK;
            end else if (addr_hit(r_shift, own_addr, GEN_CALL_EN)) begin
              w_sda_o_next     = 1'b0;
              w_addressed_next = 1'b1;
              w_rd_wr_next     = r_shift[0];
              w_tx_req_next    = r_shift[0];
              w_state_next     = ADDR_ACK;
            end else begin
              w_sda_o_next = 1'b1;
              w_state_next = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bit_cnt_next = '0;
            if (r_rd_wr) begin
              w_shift_next = tx_dat;
              w_sda_o_next = tx_dat[7];
              w_state_next = TX_DATA;
            end else begin
              w_sda_o_next = 1'b1;
              w_state_next = RX_DATA;
            end
          end
        end
        RX_ACK: begin
          if (w_scl_fall) begin
            w_sda_o_next   = 1'b1;
            w_bit_cnt_next = '0;
            w_state_next   = RX_DATA;
          end
        end
        TX_DATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_byte_full_next = 1'b1;
          end else if (w_scl_fall) begin
            if (r_byte_full) begin
              w_byte_full_next = 1'b0;
              w_sda_o_next     = 1'b1;
              w_state_next     = TX_ACK_CHK;
            end else begin
              w_sda_o_next = r_shift[6];
              w_shift_next = {r_shift[6:0], 1'b1};
            end
          end
        end
        TX_ACK_CHK: begin
          if (w_scl_rise) begin
            w_byte_full_next = 1'b1;
            w_ack_ok_next    = ~w_sda_s;
            w_tx_req_next    = ~w_sda_s;
            w_nack_next      = w_sda_s;
          end else if (w_scl_fall && r_byte_full) begin
            w_byte_full_next = 1'b0;
            if (r_ack_ok) begin
              w_shift_next   = tx_dat;
              w_sda_o_next   = tx_dat[7];
              w_bit_cnt_next = '0;
              w_state_next   = TX_DATA;
            end else begin
              w_sda_o_next = 1'b1;
              w_state_next = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_o        = r_sda_o;
  assign rx_dat       = r_rx_dat;
  assign rx_dat_valid = r_rx_valid;
  assign tx_req       = r_tx_req;
  assign rd_wr        = r_rd_wr;
  assign addressed    = r_addressed;
  assign start_det    = r_start_det;
  assign stop_det     = r_stop_det;
  assign nack_rcvd    = r_nack;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Bench for i2c_target_fsm: a bit-level I2C controller drives the bus, and
// results are compared with expectations derived from the I2C transfer rules.
module tb_i2c_target_fsm;

  localparam int Q = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       m_scl, m_sda;
  logic [6:0] own;
  logic [7:0] tx_dat;
  logic       sel;

  logic       sda_o, rx_dat_valid, tx_req, rd_wr, addressed, start_det, stop_det, nack_rcvd, busy;
  logic [7:0] rx_dat;
  logic       g_sda_o, g_rx_dat_valid, g_tx_req, g_rd_wr, g_addressed, g_start_det, g_stop_det, g_nack, g_busy;
  logic [7:0] g_rx_dat;
  logic       sda_main, sda_gc;

  assign sda_main = m_sda & sda_o;
  assign sda_gc   = m_sda & g_sda_o;

  i2c_target_fsm #(.SYNC_STAGES(2), .GEN_CALL_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_main), .sda_o(sda_o),
    .own_addr(own), .rx_dat(rx_dat), .rx_dat_valid(rx_dat_valid), .tx_dat(tx_dat),
    .tx_req(tx_req), .rd_wr(rd_wr), .addressed(addressed), .start_det(start_det),
    .stop_det(stop_det), .nack_rcvd(nack_rcvd), .busy(busy)
  );

  i2c_target_fsm #(.SYNC_STAGES(2), .GEN_CALL_EN(1'b1)) dut_gc (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_gc), .sda_o(g_sda_o),
    .own_addr(own), .rx_dat(g_rx_dat), .rx_dat_valid(g_rx_dat_valid), .tx_dat(tx_dat),
    .tx_req(g_tx_req), .rd_wr(g_rd_wr), .addressed(g_addressed), .start_det(g_start_det),
    .stop_det(g_stop_det), .nack_rcvd(g_nack), .busy(g_busy)
  );

  // ---------------- event monitor ----------------
  int rx_cnt = 0, tx_cnt = 0, nack_cnt = 0, start_cnt = 0, stop_cnt = 0, low_cnt = 0;
  int g_rx_cnt = 0, g_low_cnt = 0;
  logic [7:0] rx_log [256];
  logic [7:0] g_rx_log [256];
  logic [7:0] tx_mem [256];

  always @(negedge clk) begin
    if (rx_dat_valid) begin
      rx_log[rx_cnt[7:0]] <= rx_dat;
      rx_cnt <= rx_cnt + 1;
    end
    if (g_rx_dat_valid) begin
      g_rx_log[g_rx_cnt[7:0]] <= g_rx_dat;
      g_rx_cnt <= g_rx_cnt + 1;
    end
    if (tx_req)    tx_cnt    <= tx_cnt + 1;
    if (nack_rcvd) nack_cnt  <= nack_cnt + 1;
    if (start_det) start_cnt <= start_cnt + 1;
    if (stop_det)  stop_cnt  <= stop_cnt + 1;
    if (!sda_o)    low_cnt   <= low_cnt + 1;
    if (!g_sda_o)  g_low_cnt <= g_low_cnt + 1;
  end

  // Each tx_req advances to the next queued read byte.
  assign tx_dat = tx_mem[8'(tx_cnt - 1)];

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- bit-level controller ----------------
  task automatic hclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    hclk(Q); m_sda = b;
    hclk(Q); m_scl = 1'b1;
    hclk(2*Q); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    hclk(Q); m_sda = 1'b1;
    hclk(Q); m_scl = 1'b1;
    hclk(Q); b = sel ? sda_gc : sda_main;
    hclk(Q); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    hclk(Q); m_sda = 1'b1;
    hclk(Q); m_scl = 1'b1;
    hclk(Q); m_sda = 1'b0;
    hclk(Q); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    hclk(Q); m_sda = 1'b0;
    hclk(Q); m_scl = 1'b1;
    hclk(Q); m_sda = 1'b1;
    hclk(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  logic [7:0] wr_buf [4];
  logic [7:0] rd_buf [4];
  int   dack;
  logic busy_pre, addr_seen;

  task automatic do_txn(input logic [6:0] a, input logic rw, input int nb, output logic ack);
    logic a2;
    logic [7:0] d;
    dack = 0;
    i2c_start();
    write_byte({a, rw}, ack);
    addr_seen = sel ? g_addressed : addressed;
    if (ack) begin
      for (int i = 0; i < nb; i++) begin
        if (!rw) begin
          write_byte(wr_buf[i], a2);
          if (a2) dack++;
        end else begin
          read_byte(d, i != nb - 1);
          rd_buf[i] = d;
        end
      end
    end
    busy_pre = busy;
    i2c_stop();
  endtask

  task automatic prep_tx(input int nb);
    for (int i = 0; i < nb; i++) tx_mem[8'(tx_cnt + i)] = wr_buf[i];
  endtask

  task automatic run_and_check(input string tag, input logic [6:0] a, input logic rw,
                               input logic [6:0] own_v, input int nb, input logic exp_ack,
                               input int exp_rx, input int exp_txreq, input int exp_nack);
    int s_rx, s_tx, s_nack, s_stop, s_low;
    logic ack;
    own = own_v;
    s_rx = rx_cnt; s_tx = tx_cnt; s_nack = nack_cnt; s_stop = stop_cnt; s_low = low_cnt;
    if (rw) prep_tx(nb);
    do_txn(a, rw, nb, ack);
    hclk(2);
    check({tag, " addr_ack"}, int'(ack), int'(exp_ack));
    check({tag, " addressed"}, int'(addr_seen), int'(exp_ack));
    check({tag, " rx_count"}, rx_cnt - s_rx, exp_rx);
    for (int i = 0; i < exp_rx; i++)
      check({tag, " rx_data"}, int'(rx_log[8'(s_rx + i)]), int'(wr_buf[i]));
    if (!rw && exp_ack) check({tag, " data_ack"}, dack, nb);
    check({tag, " tx_req_count"}, tx_cnt - s_tx, exp_txreq);
    if (rw && exp_ack)
      for (int i = 0; i < nb; i++)
        check({tag, " rd_data"}, int'(rd_buf[i]), int'(wr_buf[i]));
    check({tag, " nack_count"}, nack_cnt - s_nack, exp_nack);
    check({tag, " stop_det"}, stop_cnt - s_stop, 1);
    check({tag, " busy_before_stop"}, int'(busy_pre), 1);
    check({tag, " busy_after_stop"}, int'(busy), 0);
    if (!exp_ack) check({tag, " sda_never_low"}, low_cnt - s_low, 0);
    $display("txn %s: addr=%02h rw=%0d own=%02h nb=%0d ack=%0d", tag, a, rw, own_v, nb, ack);
  endtask

  // Reference: an address is claimed only by an exact 7-bit match, or by the
  // general call (0x00) when enabled and the transfer is a write.
  function automatic logic model_ack(input logic [6:0] a, input logic rw,
                                     input logic [6:0] o, input logic gen);
    return (a == o) || (gen && a == 7'h00 && !rw);
  endfunction

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [6:0] own_v;
    int         nb;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    int         exp_rx;
    int         exp_txreq;
    int         exp_nack;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic ack, b;
    logic [7:0] d;
    logic [6:0] ra, ro;
    logic rrw, eack;
    int rnb, s_rx, s_low, s_grx, s_glow, s_start, s_stop;

    for (int i = 0; i < 256; i++) tx_mem[i] = 8'h00;
    sel = 1'b0; own = 7'h50; m_scl = 1'b1; m_sda = 1'b1; rst = 1'b1;
    hclk(3);
    check("reset sda_o", int'(sda_o), 1);
    check("reset busy", int'(busy), 0);
    check("reset addressed", int'(addressed), 0);
    check("reset rx_dat", int'(rx_dat), 0);
    check("reset pulses", int'({rx_dat_valid, tx_req, start_det, stop_det, nack_rcvd}), 0);
    check("reset rd_wr", int'(rd_wr), 0);
    rst = 1'b0;
    hclk(5);

    vecs[0] = '{7'h50, 1'b0, 7'h50, 2, 8'h5A, 8'hC3, 1'b1, 2, 0, 0};
    vecs[1] = '{7'h50, 1'b1, 7'h50, 2, 8'h81, 8'h7E, 1'b1, 0, 2, 1};
    vecs[2] = '{7'h51, 1'b0, 7'h50, 1, 8'h33, 8'h00, 1'b0, 0, 0, 0};
    vecs[3] = '{7'h00, 1'b0, 7'h50, 1, 8'h06, 8'h00, 1'b0, 0, 0, 0};
    vecs[4] = '{7'h2A, 1'b1, 7'h2A, 1, 8'hA5, 8'h00, 1'b1, 0, 1, 1};
    vecs[5] = '{7'h50, 1'b1, 7'h51, 1, 8'h11, 8'h00, 1'b0, 0, 0, 0};
    for (int v = 0; v < 6; v++) begin
      wr_buf[0] = vecs[v].d0;
      wr_buf[1] = vecs[v].d1;
      run_and_check($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rw, vecs[v].own_v,
                    vecs[v].nb, vecs[v].exp_ack, vecs[v].exp_rx, vecs[v].exp_txreq,
                    vecs[v].exp_nack);
    end

    // Write, repeated START, then read from the same target.
    own = 7'h50;
    s_rx = rx_cnt; s_start = start_cnt; s_stop = stop_cnt;
    wr_buf[0] = 8'hC5;
    prep_tx(1);
    i2c_start();
    write_byte(8'hA0, ack);
    check("rs addr_w_ack", int'(ack), 1);
    write_byte(8'h10, ack);
    check("rs data_ack", int'(ack), 1);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rs addr_r_ack", int'(ack), 1);
    check("rs rd_wr", int'(rd_wr), 1);
    read_byte(d, 1'b0);
    i2c_stop();
    hclk(2);
    check("rs start_det", start_cnt - s_start, 2);
    check("rs stop_det", stop_cnt - s_stop, 1);
    check("rs rx_count", rx_cnt - s_rx, 1);
    check("rs rx_dat", int'(rx_log[8'(s_rx)]), 8'h10);
    check("rs rd_data", int'(d), 8'hC5);
    $display("txn repeated_start: wrote 10 read %02h", d);

    // Reset in the middle of a data byte, then a clean write.
    s_rx = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("rst addr_ack", int'(ack), 1);
    for (int i = 7; i >= 4; i--) send_bit(i[0]);
    rst = 1'b1;
    hclk(1);
    check("rst sda_o", int'(sda_o), 1);
    check("rst addressed", int'(addressed), 0);
    check("rst busy", int'(busy), 0);
    rst = 1'b0;
    s_low = low_cnt;
    for (int i = 3; i >= 0; i--) send_bit(i[0]);
    recv_bit(b);
    check("rst no_ack", int'(b), 1);
    i2c_stop();
    hclk(2);
    check("rst rx_count", rx_cnt - s_rx, 0);
    check("rst sda_never_low", low_cnt - s_low, 0);
    $display("txn reset_mid_rx: ack_bit=%0d", b);
    wr_buf[0] = 8'h77;
    run_and_check("post_reset", 7'h50, 1'b0, 7'h50, 1, 1'b1, 1, 0, 0);

    // General call: accepted only by the instance with it enabled.
    sel = 1'b1;
    wr_buf[0] = 8'h06;
    s_grx = g_rx_cnt; s_low = low_cnt; s_rx = rx_cnt;
    do_txn(7'h00, 1'b0, 1, ack);
    hclk(2);
    check("gc write_ack", int'(ack), 1);
    check("gc rx_count", g_rx_cnt - s_grx, 1);
    check("gc rx_dat", int'(g_rx_log[8'(s_grx)]), 8'h06);
    check("gc main_no_ack", low_cnt - s_low, 0);
    check("gc main_rx", rx_cnt - s_rx, 0);
    $display("txn gen_call_write: ack=%0d", ack);
    s_glow = g_low_cnt;
    do_txn(7'h00, 1'b1, 1, ack);
    hclk(2);
    check("gc read_nack", int'(ack), 0);
    check("gc read_sda_never_low", g_low_cnt - s_glow, 0);
    $display("txn gen_call_read: ack=%0d", ack);
    sel = 1'b0;

    // Randomised transfers against the reference model.
    for (int t = 0; t < 16; t++) begin
      ro  = (t % 4 == 3) ? 7'($urandom_range(0, 127)) : 7'h50;
      ra  = ($urandom_range(0, 2) != 0) ? ro : 7'($urandom_range(0, 127));
      rrw = 1'($urandom_range(0, 1));
      rnb = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wr_buf[i] = 8'($urandom_range(0, 255));
      eack = model_ack(ra, rrw, ro, 1'b0);
      run_and_check($sformatf("rand%0d", t), ra, rrw, ro, rnb, eack,
                    (eack && !rrw) ? rnb : 0,
                    (eack && rrw) ? rnb : 0,
                    (eack && rrw) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
